// File: rtl/vga_sync_gen.sv
// ============================================================================
// vga_sync_gen
// ----------------------------------------------------------------------------
// Pixel-timing generator for the 640x480@60 Hz VGA output path. Produces the
// horizontal/vertical beam counters used by the frame-buffer/sprite renderer,
// plus hsync, vsync, display_on and frame_tick. The four timing strobes can be
// delayed so they line up with the renderer's registered colour output.
//
// Build option:
//   VGA_SYNC_ALIGN_EN  defined   -> strobes pass through a PIPE_DELAY-deep
//                                   delay line (shifts only on pix_en).
//                      undefined -> no delay registers; strobes are the raw
//                                   combinational decode of the counters.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   pix_en       in   pixel-step enable (tie high for a 25 MHz clk)
//   counter_H    out  current column, 0..H_TOTAL-1
//   counter_V    out  current line, 0..V_TOTAL-1
//   hsync        out  horizontal sync, active-low, aligned
//   vsync        out  vertical sync, active-low, aligned
//   display_on   out  high while the aligned pixel is visible
//   frame_tick   out  one-step pulse on the last pixel of a frame, aligned
//   frame_count  out  frames completed, wraps modulo 256 (never delayed)
// ============================================================================
module vga_sync_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] counter_H,
    output logic [9:0] counter_V,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       frame_tick,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Refuse to elaborate with timings that do not fit the 10-bit counters
    // or with an alignment depth the renderer does not support.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_DELAY < 1 || PIPE_DELAY > 4)
    begin : g_param_check
        $error("vga_sync_gen: timing parameters out of range");
    end

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Window bounds are 11 bits wide so an end bound of exactly 1024 still
    // compares correctly against a 10-bit counter.
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    // One stage of timing strobes.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic ft;
    } tap_t;

    // ------------------------------------------------------------------
    // Beam counters and frame counter
    // ------------------------------------------------------------------
    logic h_wrap;
    logic v_wrap;

    assign h_wrap = (counter_H == H_LAST);
    assign v_wrap = (counter_V == V_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_H   <= 10'd0;
            counter_V   <= 10'd0;
            frame_count <= 8'd0;
        end else if (pix_en) begin
            if (h_wrap) begin
                counter_H <= 10'd0;
                if (v_wrap) begin
                    // Both counters wrap on this edge: a frame has completed.
                    counter_V   <= 10'd0;
                    frame_count <= frame_count + 8'd1;
                end else begin
                    counter_V <= counter_V + 10'd1;
                end
            end else begin
                counter_H <= counter_H + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Raw strobes decoded from the current counter values
    // ------------------------------------------------------------------
    logic [10:0] h_ext;
    logic [10:0] v_ext;
    tap_t        raw;

    assign h_ext = {1'b0, counter_H};
    assign v_ext = {1'b0, counter_V};

    assign raw.hs = ~((h_ext >= HS_START) && (h_ext < HS_END));
    assign raw.vs = ~((v_ext >= VS_START) && (v_ext < VS_END));
    assign raw.de = (h_ext < H_VIS) && (v_ext < V_VIS);
    assign raw.ft = h_wrap && v_wrap;

`ifdef VGA_SYNC_ALIGN_EN
    // ------------------------------------------------------------------
    // Alignment delay line. Reset loads every stage with the inactive
    // strobe pattern, so a reset in the middle of a sync pulse ends it at
    // once instead of letting the tail drain out.
    // ------------------------------------------------------------------
    localparam tap_t TAP_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, ft: 1'b0};

    tap_t pipe [PIPE_DELAY];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                pipe[i] <= TAP_IDLE;
            end
        end else if (pix_en) begin
            pipe[0] <= raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign hsync      = pipe[PIPE_DELAY-1].hs;
    assign vsync      = pipe[PIPE_DELAY-1].vs;
    assign display_on = pipe[PIPE_DELAY-1].de;
    assign frame_tick = pipe[PIPE_DELAY-1].ft;
`else
    // No alignment: strobes follow the counters directly. During reset the
    // counters sit at 0,0, which is a visible pixel, so display_on is high.
    assign hsync      = raw.hs;
    assign vsync      = raw.vs;
    assign display_on = raw.de;
    assign frame_tick = raw.ft;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// tb_vga_sync_gen
// ----------------------------------------------------------------------------
// Two instances share clock, reset and pix_en:
//   dut_def   : default 640x480 timing, used for line-level checks.
//   dut_small : a 16x10 total raster, so whole frames (and 256 of them)
//               fit in a short run.
// A reference model predicts every output from the number of pixel steps
// taken since reset, using plain division/modulo on the timing rules.
// ============================================================================
module tb_vga_sync_gen;

`ifdef VGA_SYNC_ALIGN_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    // Small raster: H_TOTAL = 16, V_TOTAL = 10.
    localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 3;
    localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 1;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ft;
        logic [7:0] fc;
    } obs_t;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic pix_en = 1'b1;

    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic [9:0] d_h, d_v, s_h, s_v;
    logic       d_hs, d_vs, d_de, d_ft, s_hs, s_vs, s_de, s_ft;
    logic [7:0] d_fc, s_fc;

    vga_sync_gen dut_def (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .counter_H(d_h), .counter_V(d_v),
        .hsync(d_hs), .vsync(d_vs), .display_on(d_de),
        .frame_tick(d_ft), .frame_count(d_fc)
    );

    vga_sync_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .PIPE_DELAY(2)
    ) dut_small (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .counter_H(s_h), .counter_V(s_v),
        .hsync(s_hs), .vsync(s_vs), .display_on(s_de),
        .frame_tick(s_ft), .frame_count(s_fc)
    );

    obs_t act_def, act_small;
    assign act_def   = {d_h, d_v, d_hs, d_vs, d_de, d_ft, d_fc};
    assign act_small = {s_h, s_v, s_hs, s_vs, s_de, s_ft, s_fc};

    // ---------------- scoreboard ----------------
    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pixel steps counted since the last reset.
    longint n_steps = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset)      n_steps <= 0;
        else if (pix_en) n_steps <= n_steps + 1;
    end

    function automatic obs_t predict(input longint n, input int ha, input int hf,
                                     input int hsw, input int hb, input int va,
                                     input int vf, input int vsw, input int vb);
        int     ht, vt, rh, rv;
        longint k;
        obs_t   e;
        ht   = ha + hf + hsw + hb;
        vt   = va + vf + vsw + vb;
        e.h  = 10'(n % ht);
        e.v  = 10'((n / ht) % vt);
        e.fc = 8'((n / (ht * vt)) % 256);
        if (n < D) begin
            e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.ft = 1'b0;
        end else begin
            k  = n - D;
            rh = int'(k % ht);
            rv = int'((k / ht) % vt);
            e.hs = (rh >= ha + hf && rh < ha + hf + hsw) ? 1'b0 : 1'b1;
            e.vs = (rv >= va + vf && rv < va + vf + vsw) ? 1'b0 : 1'b1;
            e.de = (rh < ha && rv < va) ? 1'b1 : 1'b0;
            e.ft = (rh == ht - 1 && rv == vt - 1) ? 1'b1 : 1'b0;
        end
        return e;
    endfunction

    // Every cycle, away from the active edge.
    always @(negedge clk) begin
        check("model_def", 64'(act_def),
              64'(predict(n_steps, 640, 16, 96, 48, 480, 10, 2, 33)));
        check("model_small", 64'(act_small),
              64'(predict(n_steps, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB)));
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input logic en);
        pix_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_h(input int target, input string name);
        int budget = 2000;
        while (d_h != 10'(target) && budget > 0) begin
            tick(1'b1);
            budget--;
        end
        check(name, d_h, target);
    endtask

    task automatic run_until_small(input int th, input int tv, input string name);
        int budget = 400;
        while (!(s_h == 10'(th) && s_v == 10'(tv)) && budget > 0) begin
            tick(1'b1);
            budget--;
        end
        check(name, {s_h, s_v}, {10'(th), 10'(tv)});
    endtask

    // Hand-computed literal pins for this build.
`ifdef VGA_SYNC_ALIGN_EN
    localparam int   DE_FALL_H = 642;
    localparam int   HS_FALL_H = 658;
    localparam int   HS_RISE_H = 754;
    localparam logic RST_DE    = 1'b0;
    localparam logic FT_LAST   = 1'b0;   // at H=15,V=9 of the small raster
    localparam logic FT_PLUS2  = 1'b1;   // two steps after H=15,V=9
`else
    localparam int   DE_FALL_H = 640;
    localparam int   HS_FALL_H = 656;
    localparam int   HS_RISE_H = 752;
    localparam logic RST_DE    = 1'b1;
    localparam logic FT_LAST   = 1'b1;
    localparam logic FT_PLUS2  = 1'b0;
`endif

    // ---------------- stimulus ----------------
    initial begin
        int budget;

        // Reset values after 3 cycles held in reset with pix_en high.
        reset  = 1'b0;
        pix_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_counter_h", d_h, 0);
        check("rst_counter_v", d_v, 0);
        check("rst_frame_count", d_fc, 0);
        check("rst_hsync", d_hs, 1);
        check("rst_vsync", d_vs, 1);
        check("rst_display_on", d_de, RST_DE);

        reset = 1'b1;

        // Enable gating at H=100: 1,0,0,1 -> 101,101,101,102.
        run_until_h(100, "reach_h100");
        tick(1'b1); check("gate_h_step1", d_h, 101);
        tick(1'b0); check("gate_h_step2", d_h, 101);
        check("gate_out_held2", {d_hs, d_vs, d_de, d_ft}, 4'b1110);
        tick(1'b0); check("gate_h_step3", d_h, 101);
        check("gate_out_held3", {d_hs, d_vs, d_de, d_ft}, 4'b1110);
        tick(1'b1); check("gate_h_step4", d_h, 102);

        // Frame wrap on the small raster (first frame, steps 159..162).
        run_until_small(15, 9, "reach_small_last");
        check("wrap_fc_before", s_fc, 0);
        check("wrap_ft_last", s_ft, FT_LAST);
        tick(1'b1);
        check("wrap_hv_zero", {s_h, s_v}, 20'd0);
        check("wrap_fc_after", s_fc, 1);
        check("wrap_ft_plus1", s_ft, 0);
        tick(1'b1);
        check("wrap_ft_plus2", s_ft, FT_PLUS2);
        tick(1'b1);
        check("wrap_ft_plus3", s_ft, 0);

        // vsync on the small raster: lines 7..8, shifted by D steps.
        run_until_small(D, 7, "reach_small_vs");
        check("small_vsync_low", s_vs, 0);
        run_until_small(D, 9, "reach_small_vs_end");
        check("small_vsync_high", s_vs, 1);

        // display_on and hsync edges on the default raster, first line.
        run_until_h(DE_FALL_H - 1, "reach_de_last");
        check("de_last_visible", d_de, 1);
        tick(1'b1);
        check("de_fall", d_de, 0);
        run_until_h(HS_FALL_H - 1, "reach_hs_pre");
        check("hs_before_fall", d_hs, 1);
        tick(1'b1);
        check("hs_fall", d_hs, 0);
        run_until_h(HS_RISE_H - 1, "reach_hs_end");
        check("hs_last_low", d_hs, 0);
        tick(1'b1);
        check("hs_rise", d_hs, 1);

        // Run the small raster to frame_count 255, then wrap to 0.
        budget = 50000;
        while (s_fc != 8'd255 && budget > 0) begin
            tick(1'b1);
            budget--;
        end
        check("reach_fc255", s_fc, 255);
        run_until_small(15, 9, "reach_small_last_255");
        check("fc_before_wrap", s_fc, 255);
        tick(1'b1);
        check("fc_wrap_zero", s_fc, 0);

        // Asynchronous reset in the middle of an hsync pulse.
        run_until_h(700, "reach_h700");
        check("mid_hsync_low", d_hs, 0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_h", d_h, 0);
        check("async_rst_hsync", d_hs, 1);
        check("async_rst_fc", {d_fc, s_fc}, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) tick(1'b1);
        check("post_rst_h", d_h, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    // Overall time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Pixel-timing generator for the 640x480@60 Hz VGA output path. It produces the horizontal and vertical beam counters (`counter_H`, `counter_V`) consumed by the frame-buffer/sprite renderer. It also produces `hsync`, `vsync`, `display_on` and a frame pulse, delayed so they line up with the renderer's registered `colour` output. It sits directly upstream of the frame buffer and alongside the final RGB output mux.

## Interface

Parameters:
- `H_ACTIVE`, default 640: visible pixels per line
- `H_FP`, default 16: horizontal front porch
- `H_SYNC`, default 96: hsync pulse width
- `H_BP`, default 48: horizontal back porch
- `V_ACTIVE`, default 480: visible lines
- `V_FP`, default 10: vertical front porch
- `V_SYNC`, default 2: vsync width
- `V_BP`, default 33: vertical back porch
- `PIPE_DELAY`, default 2: renderer latency in pixel steps, range 1..4

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `pix_en`  in  1  pixel-step enable; tie high for a 25 MHz clk
- `counter_H`  out  10  current column, 0..H_TOTAL-1
- `counter_V`  out  10  current line, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, active-low, aligned to `colour`
- `vsync`  out  1  vertical sync, active-low, aligned to `colour`
- `display_on`  out  1  high while the aligned pixel is visible
- `frame_tick`  out  1  one-pixel-step pulse on the last pixel of a frame, aligned
- `frame_count`  out  8  frames completed, wraps modulo 256

## Operation

- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, 800 by default.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, 525 by default.
- Counters are registers and advance only on a `clk` edge with `pix_en`=1.
- Horizontal counter: `counter_H` increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter: `counter_V` increments only on the step where `counter_H` wraps; at V_TOTAL-1 it wraps to 0.
- Raw signals, combinational from the counters:
  - hs_raw = 0 iff H_ACTIVE+H_FP ≤ H < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw = 0 iff V_ACTIVE+V_FP ≤ V < V_ACTIVE+V_FP+V_SYNC (490..491).
  - de_raw = (H < H_ACTIVE) && (V < V_ACTIVE).
  - ft_raw = (H == H_TOTAL-1) && (V == V_TOTAL-1).
- Alignment delay line: {hs_raw, vs_raw, de_raw, ft_raw} pass through a shift register of depth D. It shifts only when `pix_en`=1. Outputs are taken from the last stage.
- `frame_count` increments on the same step in which both counters wrap. It is not delayed.
- `frame_tick` is high for exactly one pixel step per frame: it rises on a clock where `pix_en`=1 and falls at the next such clock.
- Any `pix_en`=0 cycle freezes all state, including the delay line and outputs.
- All arithmetic is unsigned 10-bit. Parameters must satisfy H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024; elaboration fails otherwise.

## Timing

- Reset (`reset`=0, asynchronous):
  - `counter_H`=0, `counter_V`=0, `frame_count`=0.
  - Every delay stage is loaded with its inactive value: hs=1, vs=1, de=0, ft=0.
  - So `hsync`=1, `vsync`=1, `display_on`=0 and `frame_tick`=0 until D steps after release.
- Reset release: the first counted step is the first `clk` edge after deassertion with `pix_en`=1.
- Reset mid-line: counters and delay line clear immediately. No partial sync pulse is completed.
- Latency: counters have 0 latency (registered). Sync/de/frame_tick outputs correspond to the counter value D pixel steps earlier.
- With defaults, `hsync` falls D steps after `counter_H` becomes 656 and stays low 96 steps.
- `vsync` is low for 2×800 steps.
- The horizontal and vertical wrap happen on the same edge; `frame_count` updates on that edge.

## Configuration

- `VGA_SYNC_ALIGN_EN` defined: D = `PIPE_DELAY`, delay line as above.
- `VGA_SYNC_ALIGN_EN` undefined:
  - D = 0 and no delay registers are built.
  - `hsync`/`vsync`/`display_on`/`frame_tick` equal the raw combinational values.
  - `display_on`=1 during reset, since counters are 0,0.
- `frame_count` behaviour is identical in both builds.

## Test plan

- **Reset values:** hold `reset`=0 for 3 cycles with `pix_en`=1 -> counters 0, `frame_count`=0, `hsync`=1, `vsync`=1, `display_on`=0 (macro on, D=2).
- **hsync alignment:** release reset, `pix_en`=1 -> `hsync` goes 0 at the edge where `counter_H` becomes 658 and returns to 1 when `counter_H` becomes 754. `display_on` goes 0 when `counter_H` becomes 642.
- **Frame wrap:** run to H=799, V=524 -> next step H=0, V=0, `frame_count` 0→1. `frame_tick`=1 for one step two steps later. `vsync` low across V=490..491 shifted by 2 steps.
- **Enable gating:** `pix_en` toggling 1,0,0,1 at H=100 -> `counter_H` reads 101, 101, 101, 102. Outputs unchanged on gated cycles.
- **Counter wrap:** run 256 frames -> `frame_count` wraps 255→0. Assert reset at H=700 (inside hsync) -> `hsync`=1 and H=0 immediately, asynchronously.
- **Macro off:** at H=656 `hsync`=0 in the same cycle. At H=639, V=0 `display_on`=1; at H=640 it is 0.
